data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Data-SRAM slave answering the MEM stage's load/store port. Accepts word requests
//  (byte-enable writes, reads) on a valid/ready channel and returns read data on a
//  response channel after a fixed LATENCY, with credit-based backpressure.
//  Sits between the EX/MEM stages and the data memory. Replaces the bare single-cycle SRAM.
// PARAMETERS
//  ADDR_W     10  word-address bits; depth = 2**ADDR_W words of 32 bits
//  LATENCY    1   cycles from read acceptance to earliest resp_valid (legal 1..4)
//  RESP_DEPTH 4   max reads in flight + buffered responses (>= LATENCY, power of 2)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid && req_ready
//  req_we      in   4   byte write enables; 4'b0000 = read
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, byte i = wdata[8i+7:8i]
//  resp_valid  out  1   read response present
//  resp_ready  in   1   consumer takes response when resp_valid && resp_ready
//  resp_rdata  out  32  read data, stable while resp_valid && !resp_ready
// BEHAVIOUR
//  - Word index = req_addr[ADDR_W+1:2]. addr[1:0] and bits above ADDR_W+1 ignored
//    (upper bits alias).
//  - Reset: resp_valid=0, resp_rdata=0, req_ready=0 during rst. Delay pipeline,
//    response FIFO and credit counter cleared. Memory contents untouched by rst.
//  - Reset mid-operation: in-flight and buffered reads discarded, no response.
//    Writes accepted before the reset edge persist.
//  - credits_used = reads in delay pipeline + entries in response FIFO, range 0..RESP_DEPTH.
//    req_ready = !rst && credits_used < RESP_DEPTH. Writes also need req_ready
//    (single in-order channel).
//  - Write (req_we!=0): byte lanes with we[i]=1 are updated at the accept edge.
//    No response, no credit consumed.
//  - Read (req_we==0): word sampled at the accept edge. It sees every write accepted
//    in earlier cycles and none accepted later. Consumes one credit.
//  - Latency: read accepted at edge T -> resp_valid high in cycle T+LATENCY if
//    no older response is waiting. Otherwise it waits in FIFO order.
//  - Responses are strictly in request order. Each read yields exactly one response.
//  - Credit freed at the edge where resp_valid && resp_ready.
//    Same-cycle read accept + response pop leaves credits_used unchanged.
//  - With credits_used==RESP_DEPTH-1, a read accept and a pop in the same cycle
//    keeps req_ready=1 next cycle.
//  - Full: credits_used==RESP_DEPTH -> req_ready=0 until a pop. Never overflow or drop.
//  - Empty: resp_valid=0, resp_rdata holds its last value (0 after reset).
//  - FIFO pointers wrap modulo RESP_DEPTH. The counter is wide enough for RESP_DEPTH itself.
//  - No combinational path from req_* to resp_*. req_ready depends only on
//    registered state and rst.
// TESTING
//  1. Write addr 0x10 we=1111 data 0xDEADBEEF, then read 0x10 (LATENCY=1, resp_ready=1)
//     -> resp_valid one cycle after accept, rdata=0xDEADBEEF.
//  2. Byte enables: over 0xDEADBEEF write we=0101 data 0x11223344, read
//     -> rdata=0xDE22BE44. Addr 0x13 aliases word 0x10.
//  3. Backpressure: resp_ready=0, issue 5 reads (RESP_DEPTH=4) -> 4 accepted,
//     req_ready=0 on the 5th. Raise resp_ready -> 4 responses in order,
//     then 5th accepted.
//  4. Full throughput: LATENCY=3, resp_ready=1, back-to-back reads of 8 words
//     -> 1 response/cycle starting 3 cycles after first accept, req_ready never drops.
//  5. Write-then-read ordering: cycle T write 0xA5A5A5A5 to 0x40, cycle T+1 read 0x40
//     -> 0xA5A5A5A5. Read at T then write at T+1 -> old value.
//  6. Reset with 3 reads in flight -> resp_valid=0 after reset, no stale responses.
//     req_ready=1 the cycle after rst drops. Memory data still readable.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-SRAM slave for the MEM stage load/store port: byte-masked writes, reads
// returned in order after a fixed latency, with credit-based backpressure.
module data_sram_responder #(
    parameter int ADDR_W     = 10,
    parameter int LATENCY    = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
);
    localparam int STAGES = LATENCY - 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic              rd_accept;
    logic              wr_accept;
    logic              pop;
    logic              push_valid;
    logic [31:0]       push_data;
    logic [31:0]       fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credits_used;
    logic [31:0]       last_rdata;
    logic              addr_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign word_idx    = req_addr[ADDR_W+1:2];
    assign addr_unused = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign rd_word     = mem[word_idx];

    // Ready is a pure function of registered credit state, so no req_* to req_ready path.
    assign req_ready  = !rst && (credits_used < CNT_W'(RESP_DEPTH));
    assign rd_accept  = req_valid && req_ready && (req_we == 4'b0000);
    assign wr_accept  = req_valid && req_ready && (req_we != 4'b0000);
    assign resp_valid = !rst && (fifo_count != '0);
    assign resp_rdata = rst ? 32'h0 : ((fifo_count != '0) ? fifo_mem[rd_ptr] : last_rdata);
    assign pop        = resp_valid && resp_ready;

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (req_we[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign push_valid = rd_accept;
            assign push_data  = rd_word;
        end else begin : g_pipe
            logic [STAGES-1:0] pv;
            logic [31:0]       pd [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_accept;
                    for (int i = 1; i < STAGES; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pd[0] <= rd_word;
                for (int i = 1; i < STAGES; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            assign push_valid = pv[STAGES-1];
            assign push_data  = pd[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Credits cover both the delay line and the FIFO, so the FIFO can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            credits_used <= '0;
            last_rdata   <= 32'h0;
        end else begin
            if (push_valid) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= ptr_inc(rd_ptr);
                last_rdata <= fifo_mem[rd_ptr];
            end
            case ({push_valid, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            case ({rd_accept, pop})
                2'b10:   credits_used <= credits_used + 1'b1;
                2'b01:   credits_used <= credits_used - 1'b1;
                default: credits_used <= credits_used;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: one LATENCY=1 and one LATENCY=3 instance checked
// every cycle against a queue-based model, plus directed literal expectations.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(10), .LATENCY(1), .RESP_DEPTH(4)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0])
    );

    data_sram_responder #(.ADDR_W(10), .LATENCY(3), .RESP_DEPTH(4)) dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1])
    );

    // Model: per instance a word array plus an ordered list of outstanding reads,
    // each tagged with the cycle from which it may be presented.
    logic [31:0] mm   [2][1024];
    logic [31:0] qd   [2][8];
    int          qdue [2][8];
    int          qn   [2];
    logic [31:0] last [2];
    int          edge_no = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit m_ready(input int i);
        return !rst && (qn[i] < 4);
    endfunction

    function automatic bit m_valid(input int i);
        return !rst && (qn[i] > 0) && (qdue[i][0] <= edge_no);
    endfunction

    function automatic logic [31:0] m_rdata(input int i);
        if (rst) return 32'h0;
        return m_valid(i) ? qd[i][0] : last[i];
    endfunction

    task automatic model_step();
        bit pop [2];
        bit acc [2];
        int w;
        for (int i = 0; i < 2; i++) begin
            pop[i] = m_valid(i) && resp_ready;
            acc[i] = req_valid[i] && m_ready(i);
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                qn[i]   = 0;
                last[i] = 32'h0;
            end else begin
                if (pop[i]) begin
                    last[i] = qd[i][0];
                    for (int j = 0; j < 7; j++) begin
                        qd[i][j]   = qd[i][j+1];
                        qdue[i][j] = qdue[i][j+1];
                    end
                    qn[i]--;
                end
                if (acc[i]) begin
                    w = int'(req_addr[11:2]);
                    if (req_we == 4'b0000) begin
                        qd[i][qn[i]]   = mm[i][w];
                        qdue[i][qn[i]] = edge_no + lat(i);
                        qn[i]++;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (req_we[b]) mm[i][w][8*b +: 8] = req_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
        edge_no++;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            qn[i]   = 0;
            last[i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                check_output($sformatf("inst%0d req_ready", i), 32'(req_ready[i]), 32'(m_ready(i)));
                check_output($sformatf("inst%0d resp_valid", i), 32'(resp_valid[i]), 32'(m_valid(i)));
                check_output($sformatf("inst%0d resp_rdata", i), resp_rdata[i], m_rdata(i));
            end
        end
    end

    // Holds one request until accepted; called and returns on a falling edge.
    task automatic apply_stimulus(input int inst, input logic [3:0] we, input logic [31:0] addr,
                                  input logic [31:0] data, output int tries);
        bit acc = 1'b0;
        tries = 0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_valid[inst] = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            acc = req_ready[inst];
            tries++;
            @(negedge clk);
        end
        req_valid[inst] = 1'b0;
        if (!acc) check_output("request timeout", 32'(acc), 32'd1);
    endtask

    task automatic expect_resp(input int inst, input logic [31:0] exp, input string name,
                               output int waits);
        bit got = 1'b0;
        waits = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (resp_valid[inst]) begin
                got = 1'b1;
                check_output(name, resp_rdata[inst], exp);
                check_output({name, " model"}, m_rdata(inst), exp);
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        if (!got) check_output({name, " timeout"}, 32'(got), 32'd1);
    endtask

    initial begin
        int t;
        int t5;
        int wt;
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int t5;
        int wt;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_we     = 4'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check_output("rst req_ready", 32'(req_ready[0]), 32'd0);
        check_output("rst resp_valid", 32'(resp_valid[1]), 32'd0);
        check_output("rst resp_rdata", resp_rdata[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post-rst req_ready", 32'(req_ready[0]), 32'd1);
        check_output("post-rst resp_rdata", resp_rdata[1], 32'h0);
        @(negedge clk);

        // Basic write then read, one-cycle latency
        apply_stimulus(0, 4'b1111, 32'h10, 32'hDEADBEEF, t);
        apply_stimulus(0, 4'b0000, 32'h10, 32'h0, t);
        expect_resp(0, 32'hDEADBEEF, "basic read", wt);
        check_output("basic latency", 32'(wt), 32'd0);

        // Byte enables and address aliasing
        apply_stimulus(0, 4'b0101, 32'h10, 32'h11223344, t);
        apply_stimulus(0, 4'b0000, 32'h13, 32'h0, t);
        expect_resp(0, 32'hDE22BE44, "byte lanes", wt);
        apply_stimulus(0, 4'b0000, 32'h1010, 32'h0, t);
        expect_resp(0, 32'hDE22BE44, "upper alias", wt);

        // Backpressure: fill all four credits, fifth must wait
        for (int k = 0; k < 5; k++) apply_stimulus(0, 4'b1111, 32'h100 + 32'(4*k), 32'hC0DE0000 + 32'(k), t);
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 4'b0000, 32'h100 + 32'(4*k), 32'h0, t);
            check_output("fill accepted first try", 32'(t), 32'd1);
        end
        fork
            apply_stimulus(0, 4'b0000, 32'h110, 32'h0, t5);
            begin
                repeat (2) begin
                    #1;
                    check_output("full req_ready", 32'(req_ready[0]), 32'd0);
                    @(negedge clk);
                end
                resp_ready = 1'b1;
                for (int k = 0; k < 5; k++) expect_resp(0, 32'hC0DE0000 + 32'(k), $sformatf("ordered resp %0d", k), wt);
            end
        join
        check_output("fifth read attempts", 32'(t5), 32'd4);

        // Full throughput on the three-cycle instance
        for (int k = 0; k < 8; k++) apply_stimulus(1, 4'b1111, 32'h200 + 32'(4*k), 32'hB0000000 + 32'(k), t);
        fork
            for (int k = 0; k < 8; k++) begin
                apply_stimulus(1, 4'b0000, 32'h200 + 32'(4*k), 32'h0, t);
                check_output("stream accepted first try", 32'(t), 32'd1);
            end
            for (int k = 0; k < 8; k++) begin
                expect_resp(1, 32'hB0000000 + 32'(k), $sformatf("stream resp %0d", k), wt);
                check_output($sformatf("stream gap %0d", k), 32'(wt), (k == 0) ? 32'd3 : 32'd0);
            end
        join

        // Write/read ordering in adjacent cycles
        fork
            begin
                apply_stimulus(0, 4'b1111, 32'h40, 32'hA5A5A5A5, t);
                apply_stimulus(0, 4'b0000, 32'h40, 32'h0, t);
            end
            expect_resp(0, 32'hA5A5A5A5, "write then read", wt);
        join
        fork
            begin
                apply_stimulus(0, 4'b0000, 32'h40, 32'h0, t);
                apply_stimulus(0, 4'b1111, 32'h40, 32'h5A5A5A5A, t);
            end
            expect_resp(0, 32'hA5A5A5A5, "read then write", wt);
        join
        apply_stimulus(0, 4'b0000, 32'h40, 32'h0, t);
        expect_resp(0, 32'h5A5A5A5A, "later read", wt);

        // Reset with reads in flight
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) apply_stimulus(1, 4'b0000, 32'h200 + 32'(4*k), 32'h0, t);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rst drop req_ready", 32'(req_ready[1]), 32'd1);
        check_output("rst drop resp_valid", 32'(resp_valid[1]), 32'd0);
        check_output("rst drop resp_rdata", resp_rdata[1], 32'h0);
        @(negedge clk);
        resp_ready = 1'b1;
        repeat (5) begin
            #1;
            check_output("no stale resp", 32'(resp_valid[1]), 32'd0);
            @(negedge clk);
        end
        apply_stimulus(1, 4'b0000, 32'h204, 32'h0, t);
        expect_resp(1, 32'hB0000001, "mem after rst l3", wt);
        apply_stimulus(0, 4'b0000, 32'h40, 32'h0, t);
        expect_resp(0, 32'h5A5A5A5A, "mem after rst l1", wt);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
